// File: rtl/effect_delay.sv
// Feedback echo stage: circular sample buffer with 1/2 feedback, selectable delay length.
// One sample per i_valid pulse; the result appears on o_data/o_valid three cycles later.
module effect_delay #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic                     i_enable,
   input  logic [2:0]               i_level,
   input  logic signed [DATA_W-1:0] i_data,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     o_valid
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RD, S_MIX} state_t;

   state_t                    state, state_nxt;
   logic [DATA_W-1:0]         mem [DEPTH];
   logic [ADDR_W-1:0]         wr_ptr, rd_addr;
   logic [ADDR_W:0]           fill, len;
   logic signed [DATA_W-1:0]  x, rd_data, d, y, wr_val, out_val;
   logic signed [DATA_W:0]    sum;
   logic                      en;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_valid) state_nxt = S_RD;
         S_RD:    state_nxt = S_MIX;
         S_MIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Level 7 gives len = DEPTH, whose low bits are zero: the read lands on wr_ptr (oldest sample).
   assign rd_addr = wr_ptr - len[ADDR_W-1:0];

   always_comb begin
      d   = (fill >= len) ? rd_data : '0;
      sum = {x[DATA_W-1], x} + {d[DATA_W-1], d[DATA_W-1], d[DATA_W-1:1]};
      y   = sum[DATA_W-1:0];
      if (sum[DATA_W] != sum[DATA_W-1]) y = sum[DATA_W] ? SAT_MIN : SAT_MAX;
      wr_val  = en ? y : '0;
      out_val = en ? y : x;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         wr_ptr  <= '0;
         fill    <= '0;
         x       <= '0;
         en      <= 1'b0;
         len     <= '0;
      end else begin
         o_valid <= 1'b0;
         if (state == S_IDLE && i_valid) begin
            x   <= i_data;
            en  <= i_enable;
            len <= ({{(ADDR_W - 2){1'b0}}, i_level} + 1'b1) << (ADDR_W - 3);
         end
         if (state == S_MIX) begin
            o_data  <= out_val;
            o_valid <= 1'b1;
            wr_ptr  <= wr_ptr + 1'b1;
            if (fill != FULL) fill <= fill + 1'b1;
         end
      end
   end

   // NOTE: the buffer RAM has no reset; fill masks contents not yet written since reset.
   always_ff @(posedge i_clk) begin
      if (state == S_RD)  rd_data <= mem[rd_addr];
      if (state == S_MIX) mem[wr_ptr] <= wr_val;
   end

endmodule
